// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between NUM_REQ requesters
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   req_valid/req_ready  per-requester operation handshake (req_ready at most one-hot)
//   req_a/req_b/req_op   packed per-requester operands and opcode
//   alu_a/alu_b/alu_op   registered operands driven onto the shared ALU
//   alu_out/alu_c        ALU result and carry (combinational from alu_*)
//   rsp_valid/rsp_ready  one-hot response handshake to the granted requester
//   rsp_data/rsp_c       captured ALU result and carry
//   grant_id             index of the current or last granted requester
//   busy                 high whenever an operation is in flight
module alu_arbiter #(
  parameter int WIDTH   = 4,
  parameter int OP_W    = 2,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [OP_W-1:0]         alu_op,
  input  logic [WIDTH-1:0]        alu_out,
  input  logic                    alu_c,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_c,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q;
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W:0]       idx;
  logic [NUM_REQ-1:0]  win_oh;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [WIDTH-1:0]    sel_a, sel_b;
  logic [OP_W-1:0]     sel_op;
  logic                accept;
  logic                rsp_done;

  // Rotating priority search. Walking the offsets downward lets the
  // smallest offset from ptr (the highest-priority requester) win last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
      if (req_valid[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

  // Decode winner/grant to one-hot and select the winning operand slices.
  always_comb begin
    win_oh = '0;
    gnt_oh = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i] = (win_id == ID_W'(i));
      gnt_oh[i] = (grant_id == ID_W'(i));
      if (win_id == ID_W'(i)) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  assign accept    = (state_q == IDLE) && win_found;
  assign req_ready = accept ? win_oh : '0;
  // Only the granted requester's ready bit can complete the response.
  assign rsp_done  = (state_q == RESP) && |(rsp_ready & gnt_oh);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_id  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_data  <= '0;
      rsp_c     <= 1'b0;
      rsp_valid <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        alu_op   <= sel_op;
        grant_id <= win_id;
        ptr_q    <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      end
      // The ALU has had a full cycle on the registered operands by now.
      if (state_q == EXEC) begin
        rsp_data  <= alu_out;
        rsp_c     <= alu_c;
        rsp_valid <= gnt_oh;
      end
      if (rsp_done) rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int OW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]  req_a, req_b;
  logic [N*OW-1:0] req_op;
  logic [W-1:0]    alu_a, alu_b, alu_out, rsp_data;
  logic [OW-1:0]   alu_op;
  logic            alu_c, rsp_c;
  logic [1:0]      grant_id;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;
  int ptr      = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .OP_W(OW), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_c(rsp_c),
    .grant_id(grant_id), .busy(busy)
  );

  // ALU: 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 XOR. Returns {carry, result}.
  function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [OW-1:0] op);
    case (op)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign {alu_c, alu_out} = alu_ref(alu_a, alu_b, alu_op);

  function automatic int winner(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called at posedge+1 with the DUT idle. mode: 0 back-pressured response,
  // 1 rsp_ready held high, 2 reset asserted during EXEC.
  task automatic run_op(input logic [N-1:0] v, input logic [N*W-1:0] av,
                        input logic [N*W-1:0] bv, input logic [N*OW-1:0] ov,
                        input int mode, input int hold, input logic [N-1:0] junk);
    int w;
    logic [N-1:0] oh;
    logic [W:0] res;
    req_valid = v; req_a = av; req_b = bv; req_op = ov;
    rsp_ready = (mode == 1) ? '1 : '0;
    w  = winner(v);
    oh = (w >= 0) ? N'(1) << w : '0;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(oh));
    check("idle_busy", 32'(busy), 0);
    check("idle_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    if (w < 0) return;
    ptr = (w + 1) % N;
    res = alu_ref(av[w*W +: W], bv[w*W +: W], ov[w*OW +: OW]);
    if (mode == 2) begin
      req_valid = '0;
      rst = 1'b1;
      #1;
      check("rst_alu", 32'({alu_a, alu_b, alu_op}), 0);
      check("rst_rsp", 32'({rsp_valid, rsp_data, rsp_c}), 0);
      check("rst_busy_gid", 32'({busy, grant_id, req_ready}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      ptr = 0;
      return;
    end
    req_valid = N'($urandom);
    @(negedge clk);
    check("alu_a", 32'(alu_a), 32'(av[w*W +: W]));
    check("alu_b", 32'(alu_b), 32'(bv[w*W +: W]));
    check("alu_op", 32'(alu_op), 32'(ov[w*OW +: OW]));
    check("grant_id", 32'(grant_id), 32'(w));
    check("exec_status", 32'({busy, req_ready, rsp_valid}), 32'({1'b1, 8'h00}));
    @(posedge clk); #1;
    if (mode != 1) begin
      for (int h = 0; h < hold; h++) begin
        rsp_ready = junk & ~oh;
        @(negedge clk);
        check("hold_rsp_valid", 32'(rsp_valid), 32'(oh));
        check("hold_rsp_data", 32'({rsp_c, rsp_data}), 32'(res));
        check("hold_status", 32'({busy, req_ready}), 32'({1'b1, 4'h0}));
        @(posedge clk); #1;
      end
      rsp_ready = junk | oh;
    end
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'(oh));
    check("rsp_data", 32'({rsp_c, rsp_data}), 32'(res));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    req_a = '0; req_b = '0; req_op = '0;
    @(negedge clk);
    check("reset_alu", 32'({alu_a, alu_b, alu_op}), 0);
    check("reset_rsp", 32'({rsp_valid, rsp_data, rsp_c}), 0);
    check("reset_status", 32'({busy, grant_id, req_ready}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request on port 2: 7 + 9 = 0x10 -> data 0, carry 1.
    run_op(4'b0100, 16'h0700, 16'h0900, 8'h00, 0, 2, 4'b0000);
    // Round robin with all requesting and rsp_ready high: 3,0,1,2,3 from ptr=3.
    for (int i = 0; i < 5; i++)
      run_op(4'b1111, 16'h1234, 16'h5678, 8'b00011011, 1, 0, 4'b0000);
    // Back-pressure on port 1 for five cycles.
    run_op(4'b0010, 16'h00f0, 16'h0030, 8'b00000100, 0, 5, 4'b1101);
    // Wrong-port ready while serving port 3.
    run_op(4'b1000, 16'ha000, 16'h3000, 8'b01000000, 0, 3, 4'b0001);
    // Pointer skip: ptr is 0 after port 3, grant 0 twice (ptr 1 on the second).
    run_op(4'b0001, 16'h0005, 16'h0006, 8'h00, 0, 0, 4'b0000);
    run_op(4'b0001, 16'h0008, 16'h0003, 8'h01, 0, 0, 4'b0000);
    // Reset during EXEC, then next grant must start from port 0.
    run_op(4'b0100, 16'h0f00, 16'h0f00, 8'h00, 2, 0, 4'b0000);
    run_op(4'b1111, 16'h4321, 16'h1111, 8'h00, 1, 0, 4'b0000);

    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 9);
      run_op(N'($urandom), (N*W)'($urandom), (N*W)'($urandom), (N*OW)'($urandom),
             (r == 0) ? 2 : (r < 4) ? 1 : 0, $urandom_range(0, 5), N'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
